// File: rtl/mme_outer_product_array_if.sv
// -----------------------------------------------------------------------------
// mme_outer_product_array_if
//   Bundles the control, operand-stream and result-stream signals of the
//   outer-product compute core.
//
//   master : the engine side that issues jobs, streams A columns and B rows,
//            and accepts C rows (fetch/DMA plus write-back path).
//   slave  : the compute core itself.
//
//   Signals
//     start, mat_width, acc_mode  job issue (sampled on an accepted start)
//     busy, done                  job status
//     in_valid/in_ready           operand beat handshake, carrying a_col/b_row
//     out_valid/out_ready         result row handshake, carrying out_row,
//                                 out_row_idx and out_last
// -----------------------------------------------------------------------------
interface mme_outer_product_array_if #(
    parameter int DIM    = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int K_W    = 16
) ();

    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

    // job control
    logic                    start;
    logic [K_W-1:0]          mat_width;
    logic                    acc_mode;
    logic                    busy;
    logic                    done;

    // operand stream: A[i][k] in slice i of a_col, B[k][j] in slice j of b_row
    logic                    in_valid;
    logic                    in_ready;
    logic [DIM*DATA_W-1:0]   a_col;
    logic [DIM*DATA_W-1:0]   b_row;

    // result stream: C[r][j] in slice j of out_row
    logic                    out_valid;
    logic                    out_ready;
    logic [DIM*ACC_W-1:0]    out_row;
    logic [ROW_W-1:0]        out_row_idx;
    logic                    out_last;

    modport master (
        output start, mat_width, acc_mode,
        output in_valid, a_col, b_row,
        output out_ready,
        input  busy, done, in_ready,
        input  out_valid, out_row, out_row_idx, out_last
    );

    modport slave (
        input  start, mat_width, acc_mode,
        input  in_valid, a_col, b_row,
        input  out_ready,
        output busy, done, in_ready,
        output out_valid, out_row, out_row_idx, out_last
    );

endinterface

// File: rtl/mme_outer_product_array.sv
// -----------------------------------------------------------------------------
// mme_outer_product_array
//   Compute core of the matrix-multiply engine. Builds C (DIM x DIM) as the sum
//   of K rank-1 outer products: each accepted operand beat delivers one column
//   of A and one row of B, and every MAC cell (i,j) adds A[i][k]*B[k][j] into
//   its accumulator in a single cycle. Once K beats have been taken the array
//   drains C row-major, one row per out handshake, then pulses done.
//
//   acc_mode=1 keeps the previous C so consecutive jobs accumulate (C += AxB);
//   acc_mode=0 clears C when the job starts. K comes from mat_width at start;
//   K=0 goes straight to drain and re-emits the current C (or zeros).
//
//   Ports
//     clk    clock
//     rst_n  asynchronous reset, ACTIVE-HIGH despite the name (1 = reset);
//            aborts any job in flight and clears all accumulators
//     bus    slave side of mme_outer_product_array_if (job control, operand
//            stream, result stream)
//
//   Arithmetic: operands are signed DATA_W, products and sums wrap modulo
//   2^ACC_W (no saturation).
// -----------------------------------------------------------------------------
module mme_outer_product_array #(
    parameter int DIM    = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int K_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mme_outer_product_array_if.slave      bus
);

    localparam int ROW_W  = (DIM > 1) ? $clog2(DIM) : 1;
    // Products are formed wide enough that truncating to ACC_W afterwards
    // keeps exactly the low ACC_W bits of the true signed product.
    localparam int PROD_W = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [K_W-1:0]         k_target_q;   // K latched at start
    logic [K_W-1:0]         k_cnt_q;      // operand beats accepted so far
    logic [ROW_W-1:0]       row_q;        // row currently presented on out_row
    logic [ACC_W-1:0]       acc_q [DIM][DIM];

    logic signed [PROD_W-1:0] a_ext [DIM];
    logic signed [PROD_W-1:0] b_ext [DIM];
    logic [ACC_W-1:0]         prod  [DIM][DIM];

    logic                   busy;
    logic                   done;
    logic                   in_ready;
    logic                   out_valid;
    logic [DIM*ACC_W-1:0]   out_row;

    logic                   start_ok;
    logic                   beat_ok;
    logic                   last_beat;
    logic                   row_ok;
    logic                   last_row;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign start_ok  = bus.start && (state_q == IDLE);
    assign beat_ok   = bus.in_valid && in_ready;
    assign last_beat = (k_cnt_q == k_target_q - K_W'(1));
    assign row_ok    = out_valid && bus.out_ready;
    assign last_row  = (row_q == ROW_W'(DIM - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // K=0 has nothing to load: present the current C at once.
                    state_d = (bus.mat_width == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.in_valid && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready && last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // MAC products: one signed multiply per cell, truncated to ACC_W
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_ext[i] = PROD_W'($signed(bus.a_col[i*DATA_W +: DATA_W]));
            b_ext[i] = PROD_W'($signed(bus.b_row[i*DATA_W +: DATA_W]));
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                prod[i][j] = ACC_W'(a_ext[i] * b_ext[j]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counters and accumulator array
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            k_target_q <= '0;
            k_cnt_q    <= '0;
            row_q      <= '0;
            // NOTE: the accumulator array is reset explicitly because C is
            // architecturally visible after reset (drain with K=0, or an
            // acc_mode=1 job) and must read as zero, not as power-up junk.
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
        end else begin
            if (start_ok) begin
                k_target_q <= bus.mat_width;
                k_cnt_q    <= '0;
                row_q      <= '0;
                if (!bus.acc_mode) begin
                    for (int i = 0; i < DIM; i++) begin
                        for (int j = 0; j < DIM; j++) begin
                            acc_q[i][j] <= '0;
                        end
                    end
                end
            end

            // start is only taken in IDLE and beats only in LOAD, so these
            // two updates never collide.
            if (beat_ok) begin
                k_cnt_q <= k_cnt_q + K_W'(1);
                for (int i = 0; i < DIM; i++) begin
                    for (int j = 0; j < DIM; j++) begin
                        acc_q[i][j] <= acc_q[i][j] + prod[i][j];
                    end
                end
            end

            // Row pointer returns to 0 after the last row so out_row_idx
            // reads 0 whenever the array is idle.
            if (row_ok) begin
                row_q <= last_row ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result row mux: accumulators are frozen during DRAIN, so the row is
    // stable for as long as out_ready holds off the handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        out_row = '0;
        for (int j = 0; j < DIM; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc_q[row_q][j];
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_row     = out_row;
    assign bus.out_row_idx = row_q;
    assign bus.out_last    = out_valid && last_row;

endmodule
